// File: rtl/key_map_cam.sv
// Rewritable key->data lookup table with a registered, handshaked lookup port.
// Lowest matching valid entry wins; hit/miss responses are counted with saturation.
module key_map_cam #(
    parameter int                  NR_KEY       = 4,
    parameter int                  KEY_LEN      = 8,
    parameter int                  DATA_LEN     = 32,
    parameter int                  IDX_W        = $clog2(NR_KEY),
    parameter logic [DATA_LEN-1:0] DEFAULT_DATA = '0,
    parameter int                  CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                inv_en,
    input  logic [IDX_W-1:0]    inv_idx,
    input  logic                clr,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [KEY_LEN-1:0]  req_key,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_hit,
    output logic [IDX_W-1:0]    rsp_idx,
    output logic [DATA_LEN-1:0] rsp_data,
    output logic [CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]    miss_cnt
);

    logic [NR_KEY-1:0]   valid_q, valid_d;
    logic [KEY_LEN-1:0]  key_q  [NR_KEY];
    logic [DATA_LEN-1:0] data_q [NR_KEY];

    logic                lk_hit;
    logic [IDX_W-1:0]    lk_idx;
    logic [DATA_LEN-1:0] lk_data;

    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_hit_q, rsp_hit_d;
    logic [IDX_W-1:0]    rsp_idx_q, rsp_idx_d;
    logic [DATA_LEN-1:0] rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

    logic req_acc;
    logic rsp_acc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Table update: clr dominates; a write beats an invalidate of the same entry.
    // Index compare against each entry number also drops out-of-range indices.
    always_comb begin
        valid_d = valid_q;
        if (clr) begin
            valid_d = '0;
        end else begin
            for (int i = 0; i < NR_KEY; i++) begin
                if (wr_en && wr_idx == IDX_W'(i)) begin
                    valid_d[i] = 1'b1;
                end else if (inv_en && inv_idx == IDX_W'(i)) begin
                    valid_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NR_KEY; i++) begin
            if (!clr && wr_en && wr_idx == IDX_W'(i)) begin
                key_q[i]  <= wr_key;
                data_q[i] <= wr_data;
            end
        end
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        lk_hit  = 1'b0;
        lk_idx  = '0;
        lk_data = DEFAULT_DATA;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (valid_q[i] && key_q[i] == req_key) begin
                lk_hit  = 1'b1;
                lk_idx  = IDX_W'(i);
                lk_data = data_q[i];
            end
        end
    end

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign req_acc   = req_valid && req_ready;
    assign rsp_acc   = rsp_valid_q && rsp_ready;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_idx_d   = rsp_idx_q;
        rsp_data_d  = rsp_data_q;
        if (req_acc) begin
            rsp_valid_d = 1'b1;
            rsp_hit_d   = lk_hit;
            rsp_idx_d   = lk_idx;
            rsp_data_d  = lk_data;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Counters track the response being handed off, not the one being loaded.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (rsp_acc) begin
            if (rsp_hit_q) begin
                hit_cnt_d = sat_inc(hit_cnt_q);
            end else begin
                miss_cnt_d = sat_inc(miss_cnt_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
            rsp_data_q  <= DEFAULT_DATA;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_idx_q   <= rsp_idx_d;
            rsp_data_q  <= rsp_data_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_idx   = rsp_idx_q;
    assign rsp_data  = rsp_data_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_key_map_cam.sv
// Directed bench for key_map_cam: vector table for steady-state lookups plus
// hand-written stall, mid-transaction reset and counter saturation sequences.
module tb_key_map_cam;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [1:0]  wr_idx;
    logic [7:0]  wr_key;
    logic [31:0] wr_data;
    logic        inv_en;
    logic [1:0]  inv_idx;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_key;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;
    logic [1:0]  rsp_idx;
    logic [31:0] rsp_data;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    logic        req_ready2, rsp_valid2, rsp_hit2;
    logic [1:0]  rsp_idx2;
    logic [31:0] rsp_data2;
    logic [1:0]  hit_cnt2, miss_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_map_cam dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key), .wr_data(wr_data),
        .inv_en(inv_en), .inv_idx(inv_idx), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
        .rsp_idx(rsp_idx), .rsp_data(rsp_data),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    key_map_cam #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key), .wr_data(wr_data),
        .inv_en(inv_en), .inv_idx(inv_idx), .clr(clr),
        .req_valid(req_valid), .req_ready(req_ready2), .req_key(req_key),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit2),
        .rsp_idx(rsp_idx2), .rsp_data(rsp_data2),
        .hit_cnt(hit_cnt2), .miss_cnt(miss_cnt2)
    );

    typedef struct {
        logic        we;
        logic [1:0]  widx;
        logic [7:0]  wkey;
        logic [31:0] wdata;
        logic        ie;
        logic [1:0]  iidx;
        logic        cl;
        logic        rv;
        logic [7:0]  rkey;
        logic        rr;
        logic        ev;
        logic        eh;
        logic [1:0]  ei;
        logic [31:0] ed;
        logic [15:0] ehc;
        logic [15:0] emc;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic we, input logic [1:0] widx, input logic [7:0] wkey,
                       input logic [31:0] wdata, input logic ie, input logic [1:0] iidx,
                       input logic cl, input logic rv, input logic [7:0] rkey,
                       input logic ev, input logic eh, input logic [1:0] ei,
                       input logic [31:0] ed, input logic [15:0] ehc, input logic [15:0] emc);
        vec_t v;
        v.we = we; v.widx = widx; v.wkey = wkey; v.wdata = wdata;
        v.ie = ie; v.iidx = iidx; v.cl = cl; v.rv = rv; v.rkey = rkey; v.rr = 1'b1;
        v.ev = ev; v.eh = eh; v.ei = ei; v.ed = ed; v.ehc = ehc; v.emc = emc;
        vq.push_back(v);
    endtask

    task automatic idle();
        wr_en = 0; wr_idx = 0; wr_key = 0; wr_data = 0;
        inv_en = 0; inv_idx = 0; clr = 0;
        req_valid = 0; req_key = 0; rsp_ready = 1;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic h,
                           input logic [1:0] i, input logic [31:0] d);
        chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'(v));
        if (v) begin
            chk({tag, ".rsp_hit"},  64'(rsp_hit),  64'(h));
            chk({tag, ".rsp_idx"},  64'(rsp_idx),  64'(i));
            chk({tag, ".rsp_data"}, 64'(rsp_data), 64'(d));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic prev_v;
        idle();
        rst_n = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        chk("reset.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset.rsp_hit",   64'(rsp_hit),   64'd0);
        chk("reset.rsp_idx",   64'(rsp_idx),   64'd0);
        chk("reset.rsp_data",  64'(rsp_data),  64'd0);
        chk("reset.hit_cnt",   64'(hit_cnt),   64'd0);
        chk("reset.miss_cnt",  64'(miss_cnt),  64'd0);
        chk("reset.req_ready", 64'(req_ready), 64'd1);

        //  we idx key    data           ie iidx clr rv key    ev eh ei ed             hc mc
        add(0, 0, 8'h00, 32'h0,          0, 0,   0,  1, 8'h10, 1, 0, 0, 32'h0,          0, 0);
        add(1, 1, 8'h10, 32'hAAAA_0001,  0, 0,   0,  0, 8'h00, 0, 0, 0, 32'h0,          0, 1);
        add(1, 3, 8'h10, 32'hBBBB_0003,  0, 0,   0,  0, 8'h00, 0, 0, 0, 32'h0,          0, 1);
        add(0, 0, 8'h00, 32'h0,          0, 0,   0,  1, 8'h10, 1, 1, 1, 32'hAAAA_0001,  0, 1);
        add(0, 0, 8'h00, 32'h0,          1, 1,   0,  1, 8'h10, 1, 1, 1, 32'hAAAA_0001,  1, 1);
        add(0, 0, 8'h00, 32'h0,          0, 0,   0,  1, 8'h10, 1, 1, 3, 32'hBBBB_0003,  2, 1);
        add(0, 0, 8'h00, 32'h0,          0, 0,   0,  1, 8'h55, 1, 0, 0, 32'h0,          3, 1);
        add(1, 0, 8'h22, 32'h5,          0, 0,   0,  1, 8'h22, 1, 0, 0, 32'h0,          3, 2);
        add(0, 0, 8'h00, 32'h0,          0, 0,   0,  1, 8'h22, 1, 1, 0, 32'h5,          3, 3);
        add(1, 2, 8'h33, 32'h7,          0, 0,   1,  1, 8'h10, 1, 1, 3, 32'hBBBB_0003,  4, 3);
        add(0, 0, 8'h00, 32'h0,          0, 0,   0,  1, 8'h33, 1, 0, 0, 32'h0,          5, 3);
        add(0, 0, 8'h00, 32'h0,          0, 0,   0,  1, 8'h10, 1, 0, 0, 32'h0,          5, 4);
        add(0, 0, 8'h00, 32'h0,          0, 0,   0,  1, 8'h22, 1, 0, 0, 32'h0,          5, 5);
        add(1, 2, 8'h44, 32'h9,          1, 2,   0,  0, 8'h00, 0, 0, 0, 32'h0,          5, 6);
        add(0, 0, 8'h00, 32'h0,          0, 0,   0,  1, 8'h44, 1, 1, 2, 32'h9,          5, 6);
        add(0, 0, 8'h00, 32'h0,          0, 0,   0,  0, 8'h00, 0, 0, 0, 32'h0,          6, 6);

        prev_v = 1'b0;
        for (int n = 0; n < vq.size(); n++) begin
            string tag;
            tag = $sformatf("vec%0d", n);
            wr_en = vq[n].we; wr_idx = vq[n].widx; wr_key = vq[n].wkey; wr_data = vq[n].wdata;
            inv_en = vq[n].ie; inv_idx = vq[n].iidx; clr = vq[n].cl;
            req_valid = vq[n].rv; req_key = vq[n].rkey; rsp_ready = vq[n].rr;
            #1;
            chk({tag, ".req_ready"}, 64'(req_ready), 64'(!prev_v || vq[n].rr));
            @(negedge clk);
            chk_rsp(tag, vq[n].ev, vq[n].eh, vq[n].ei, vq[n].ed);
            chk({tag, ".hit_cnt"},  64'(hit_cnt),  64'(vq[n].ehc));
            chk({tag, ".miss_cnt"}, 64'(miss_cnt), 64'(vq[n].emc));
            prev_v = vq[n].ev;
        end

        // Stall: hold response for 3 cycles while invalidating the matched entry
        idle();
        req_valid = 1; req_key = 8'h44;
        @(negedge clk);
        chk_rsp("stall.load", 1, 1, 2, 32'h9);
        rsp_ready = 0; req_key = 8'h99; inv_en = 1; inv_idx = 2;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall.req_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
            inv_en = 0;
            chk_rsp("stall.hold", 1, 1, 2, 32'h9);
            chk("stall.hit_cnt",  64'(hit_cnt),  64'd6);
            chk("stall.miss_cnt", 64'(miss_cnt), 64'd6);
        end
        req_valid = 0; rsp_ready = 1;
        @(negedge clk);
        chk("stall.release_valid", 64'(rsp_valid), 64'd0);
        chk("stall.release_hit_cnt", 64'(hit_cnt), 64'd7);
        req_valid = 1; req_key = 8'h44;
        @(negedge clk);
        chk_rsp("stall.after_inv", 1, 0, 0, 32'h0);
        req_valid = 0;
        @(negedge clk);
        chk("stall.after_inv_miss_cnt", 64'(miss_cnt), 64'd7);

        // Reset while a response is stalled
        req_valid = 1; req_key = 8'h44; rsp_ready = 0;
        @(negedge clk);
        chk("rstmid.pending", 64'(rsp_valid), 64'd1);
        #2 rst_n = 0;
        #1;
        chk("rstmid.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rstmid.hit_cnt",   64'(hit_cnt),   64'd0);
        chk("rstmid.miss_cnt",  64'(miss_cnt),  64'd0);
        chk("rstmid.sat_hit_cnt", 64'(hit_cnt2), 64'd0);
        idle();
        @(negedge clk);
        rst_n = 1;
        req_valid = 1; req_key = 8'h44;
        @(negedge clk);
        chk_rsp("rstmid.lookup44", 1, 0, 0, 32'h0);
        req_key = 8'h10;
        @(negedge clk);
        chk_rsp("rstmid.lookup10", 1, 0, 0, 32'h0);
        req_valid = 0;
        @(negedge clk);
        chk("rstmid.miss_cnt_after", 64'(miss_cnt), 64'd2);
        chk("rstmid.hit_cnt_after",  64'(hit_cnt),  64'd0);

        // Saturation: five hit handshakes into the 2-bit counter instance
        wr_en = 1; wr_idx = 0; wr_key = 8'h01; wr_data = 32'h1;
        @(negedge clk);
        wr_en = 0;
        req_valid = 1; req_key = 8'h01;
        repeat (5) @(negedge clk);
        chk_rsp("sat.last", 1, 1, 0, 32'h1);
        req_valid = 0;
        @(negedge clk);
        chk("sat.hit_cnt_w16", 64'(hit_cnt),   64'd5);
        chk("sat.hit_cnt_w2",  64'(hit_cnt2),  64'd3);
        chk("sat.miss_cnt_w2", 64'(miss_cnt2), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
